// File: rtl/branch_resolve_update_unit.sv
// Branch resolve/update unit: tracks fetch-time BTB predictions through D/E, redirects fetch on
// a misprediction and queues corrective BTB writes that drain only while fetch leaves the port idle.
module branch_resolve_update_unit #(
  parameter int          QDEPTH  = 4,
  parameter logic [31:0] INVALID = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] pcF,
  input  logic        pred_foundF,
  input  logic [31:0] pred_targetF,
  input  logic        branchE,
  input  logic        takenE,
  input  logic [31:0] targetE,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  input  logic        btb_access,
  output logic        upd_valid,
  output logic [31:0] upd_pc,
  output logic [31:0] upd_target,
  output logic        queue_full,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispred
);

  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(QDEPTH);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        found;
    logic [31:0] target;
  } slot_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
  } upd_t;

  slot_t        slot_d, slot_e;
  upd_t         mem [QDEPTH];
  upd_t         enq_entry;
  logic [PW-1:0] head, tail;
  logic [PW:0]   count;
  logic         res, mispred, enq, push, pop, empty;

  assign res     = slot_e.valid & branchE & ~stall;
  assign mispred = res & ((slot_e.found != takenE) | (takenE & (slot_e.target != targetE)));

  // NOTE: always_comb with every output defaulted first so no path can infer a latch.
  always_comb begin
    enq       = 1'b0;
    enq_entry = '{pc: slot_e.pc, target: targetE};
    if (res) begin
      if (takenE && (!slot_e.found || slot_e.target != targetE)) begin
        enq = 1'b1;
      end else if (!takenE && slot_e.found) begin
        enq              = 1'b1;
        enq_entry.target = INVALID;
      end
    end
  end

  assign empty      = (count == '0);
  assign queue_full = (count == CNT_FULL);
  assign upd_valid  = ~empty & ~btb_access;
  assign upd_pc     = mem[head].pc;
  assign upd_target = mem[head].target;
  assign pop        = upd_valid;
  // A full queue still accepts a new entry when the head leaves on the same edge.
  assign push       = enq & (~queue_full | pop);

  // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_d        <= '0;
      slot_e        <= '0;
      redirect      <= 1'b0;
      redirect_pc   <= '0;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      redirect <= mispred;
      if (mispred) redirect_pc <= takenE ? targetE : slot_e.pc + 32'd4;

      if (!stall) begin
        slot_e <= slot_d;
        slot_d <= '{valid: ~redirect, pc: pcF, found: pred_foundF, target: pred_targetF};
        if (mispred) begin
          slot_e.valid <= 1'b0;
          slot_d.valid <= 1'b0;
        end
      end

      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (res && stat_branches != '1) stat_branches <= stat_branches + 1'b1;
      if (mispred && stat_mispred != '1) stat_mispred <= stat_mispred + 1'b1;
    end
  end

  // NOTE: queue storage has no reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= enq_entry;
  end

endmodule

// File: tb/tb_branch_resolve_update_unit.sv
// Directed bench for branch_resolve_update_unit: prediction checks, redirect, update queue
// ordering/overflow, stall freeze and asynchronous reset.
module tb_branch_resolve_update_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] pcF;
  logic        pred_foundF;
  logic [31:0] pred_targetF;
  logic        branchE;
  logic        takenE;
  logic [31:0] targetE;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        btb_access;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        queue_full;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  int checks = 0;
  int errors = 0;
  int exp_br = 0;
  int exp_mp = 0;

  branch_resolve_update_unit dut (
    .clk(clk), .reset(reset), .stall(stall),
    .pcF(pcF), .pred_foundF(pred_foundF), .pred_targetF(pred_targetF),
    .branchE(branchE), .takenE(takenE), .targetE(targetE),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .btb_access(btb_access), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .queue_full(queue_full), .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fetch one instruction, push a filler behind it, resolve it in E; returns just after the
  // resolving edge with the E-side inputs released.
  task automatic run_branch(input logic [31:0] pc, input logic found, input logic [31:0] ptgt,
                            input logic taken, input logic [31:0] tgt);
    pcF = pc; pred_foundF = found; pred_targetF = ptgt;
    step();
    pcF = 32'h1000; pred_foundF = 1'b0; pred_targetF = '0;
    step();
    branchE = 1'b1; takenE = taken; targetE = tgt;
    step();
    branchE = 1'b0; takenE = 1'b0; targetE = '0;
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_branches"}, stat_branches, 32'(exp_br));
    check({tag, "_mispred"},  stat_mispred,  32'(exp_mp));
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; pcF = '0; pred_foundF = 1'b0; pred_targetF = '0;
    branchE = 1'b0; takenE = 1'b0; targetE = '0; btb_access = 1'b0;
    #1;
    check("rst_redirect", 32'(redirect), 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_upd_valid", 32'(upd_valid), 32'd0);
    check("rst_queue_full", 32'(queue_full), 32'd0);
    check_stats("rst");
    #20 reset = 1'b0;
    btb_access = 1'b1;
    step();

    // 1: correct taken prediction
    run_branch(32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
    exp_br++;
    check("t1_redirect", 32'(redirect), 32'd0);
    check_stats("t1");
    btb_access = 1'b0; #1;
    check("t1_no_upd", 32'(upd_valid), 32'd0);
    btb_access = 1'b1;
    step();

    // 2: cold miss, taken
    run_branch(32'h44, 1'b0, 32'h0, 1'b1, 32'h100);
    exp_br++; exp_mp++;
    check("t2_redirect", 32'(redirect), 32'd1);
    check("t2_redirect_pc", redirect_pc, 32'h100);
    check_stats("t2");
    // E was squashed, so a branch signalled now must not resolve
    branchE = 1'b1; takenE = 1'b1; targetE = 32'h999;
    step();
    branchE = 1'b0; takenE = 1'b0; targetE = '0;
    check("t2_redirect_pulse", 32'(redirect), 32'd0);
    check_stats("t2_squash");
    check("t2_upd_held", 32'(upd_valid), 32'd0);
    btb_access = 1'b0; #1;
    check("t2_upd_valid", 32'(upd_valid), 32'd1);
    check("t2_upd_pc", upd_pc, 32'h44);
    check("t2_upd_target", upd_target, 32'h100);
    step();
    check("t2_drained", 32'(upd_valid), 32'd0);
    btb_access = 1'b1;

    // 3: false hit, not taken
    run_branch(32'h48, 1'b1, 32'h90, 1'b0, 32'h0);
    exp_br++; exp_mp++;
    check("t3_redirect", 32'(redirect), 32'd1);
    check("t3_redirect_pc", redirect_pc, 32'h4C);
    check_stats("t3");
    step();
    btb_access = 1'b0; #1;
    check("t3_upd_pc", upd_pc, 32'h48);
    check("t3_upd_target", upd_target, 32'hFFFF_FFFF);
    step();
    check("t3_drained", 32'(upd_valid), 32'd0);
    btb_access = 1'b1;

    // 4: six mispredicts with the BTB port busy; last two are dropped
    for (int i = 0; i < 6; i++) begin
      run_branch(32'h200 + 32'(4 * i), 1'b0, 32'h0, 1'b1, 32'h300 + 32'(16 * i));
      exp_br++; exp_mp++;
      check($sformatf("t4_full_%0d", i), 32'(queue_full), (i >= 3) ? 32'd1 : 32'd0);
      step();
    end
    check_stats("t4");
    btb_access = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_valid_%0d", i), 32'(upd_valid), 32'd1);
      check($sformatf("t4_pc_%0d", i), upd_pc, 32'h200 + 32'(4 * i));
      check($sformatf("t4_tgt_%0d", i), upd_target, 32'h300 + 32'(16 * i));
      step();
    end
    check("t4_empty", 32'(upd_valid), 32'd0);
    check("t4_not_full", 32'(queue_full), 32'd0);
    btb_access = 1'b1;

    // 5: stall freezes a mispredicting branch in E
    pcF = 32'h500; pred_foundF = 1'b0; pred_targetF = '0;
    step();
    pcF = 32'h1000;
    step();
    stall = 1'b1; branchE = 1'b1; takenE = 1'b1; targetE = 32'h600;
    step();
    step();
    check("t5_stall_redirect", 32'(redirect), 32'd0);
    check_stats("t5_stall");
    stall = 1'b0;
    step();
    branchE = 1'b0; takenE = 1'b0; targetE = '0;
    exp_br++; exp_mp++;
    check("t5_redirect", 32'(redirect), 32'd1);
    check("t5_redirect_pc", redirect_pc, 32'h600);
    check_stats("t5");
    step();

    // 6: reset with three queued updates
    for (int i = 0; i < 2; i++) begin
      run_branch(32'h700 + 32'(4 * i), 1'b0, 32'h0, 1'b1, 32'h800);
      step();
    end
    #2;
    reset = 1'b1; btb_access = 1'b0;
    #1;
    exp_br = 0; exp_mp = 0;
    check("t6_upd_valid", 32'(upd_valid), 32'd0);
    check("t6_queue_full", 32'(queue_full), 32'd0);
    check("t6_redirect", 32'(redirect), 32'd0);
    check_stats("t6");
    #10 reset = 1'b0;
    step();
    check("t6_still_empty", 32'(upd_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
